digiled_axi_slave: RTL

DIGILED_AXI_SLAVE -- requirements
Module: digiled_axi_slave

---
 rtl/digiled_axi_slave.sv | 118 +++++++++++
 1 files changed

// File: rtl/digiled_axi_slave.sv
// AXI4-Lite slave exposing four 32-bit read/write registers to the LED engine.
// Write and read channels run independently; each accepts one transaction at a time.
module digiled_axi_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                              S_AXI_ACLK,
  input  logic                              S_AXI_ARESETN,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY,
  output logic [4*C_S_AXI_DATA_WIDTH-1:0]   led_regs,
  output logic [3:0]                        reg_wr_pulse
);

  localparam int unsigned NUM_REGS = 4;
  localparam int unsigned STRB_W   = C_S_AXI_DATA_WIDTH / 8;
  localparam int unsigned IDX_W    = 2;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic             wr_start_c;
  logic             wr_hs;
  logic             rd_start_c;
  logic             rd_hs;
  logic [IDX_W-1:0] aw_idx;
  logic [IDX_W-1:0] ar_idx;
  logic             unused_ok;

  // Only the word index is decoded; byte offset and protection are don't-cares.
  assign aw_idx    = S_AXI_AWADDR[3:2];
  assign ar_idx    = S_AXI_ARADDR[3:2];
  assign unused_ok = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Ready pulses last one cycle and never re-fire back to back.
  assign wr_start_c = S_AXI_AWVALID && S_AXI_WVALID && !S_AXI_BVALID && !S_AXI_AWREADY;
  assign wr_hs      = S_AXI_AWREADY && S_AXI_AWVALID && S_AXI_WREADY && S_AXI_WVALID;
  assign rd_start_c = S_AXI_ARVALID && !S_AXI_RVALID && !S_AXI_ARREADY;
  assign rd_hs      = S_AXI_ARREADY && S_AXI_ARVALID;

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  // Write address/data acceptance, response and per-register strobe.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      reg_wr_pulse  <= '0;
    end else begin
      S_AXI_AWREADY <= wr_start_c;
      S_AXI_WREADY  <= wr_start_c;
      reg_wr_pulse  <= wr_hs ? (NUM_REGS'(1) << aw_idx) : '0;
      if (wr_hs) begin
        S_AXI_BVALID <= 1'b1;
      end else if (S_AXI_BVALID && S_AXI_BREADY) begin
        S_AXI_BVALID <= 1'b0;
      end
    end
  end

  // Register file with byte-lane write enables.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        regs[r] <= '0;
      end
    end else if (wr_hs) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (S_AXI_WSTRB[b]) begin
          regs[aw_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
        end
      end
    end
  end

  // Read channel; RDATA captures the pre-write value on a colliding edge.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      S_AXI_ARREADY <= rd_start_c;
      if (rd_hs) begin
        S_AXI_RVALID <= 1'b1;
        S_AXI_RDATA  <= regs[ar_idx];
      end else if (S_AXI_RVALID && S_AXI_RREADY) begin
        S_AXI_RVALID <= 1'b0;
      end
    end
  end

  always_comb begin
    led_regs = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      led_regs[r*C_S_AXI_DATA_WIDTH +: C_S_AXI_DATA_WIDTH] = regs[r];
    end
  end

endmodule
